// File: rtl/flasher_pkg.sv
// Shared definitions for the bound_flasher control slice: sequencer state
// encoding, the flasher's idle encoding and the default launch timeout.
package flasher_pkg;

    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned GAP_W_DEF = 8;
    localparam int unsigned TMO_DEF   = 4;

    // bound_flasher reports this state encoding when it is not flashing
    localparam logic [1:0] FLASHER_IDLE = 2'b00;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_LAUNCH    = 3'd1,
        SEQ_WAIT_BUSY = 3'd2,
        SEQ_RUN       = 3'd3,
        SEQ_GAP       = 3'd4
    } seq_state_e;

endpackage

// File: rtl/flick_edge_sync.sv
// Manual button front end: optional 2-flop synchronizer (FLICK_SYNC_EN)
// followed by a rising-edge detector producing a registered one-cycle pulse.
module flick_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_pulse
);

    logic btn_s;
    logic prev_q;

`ifdef FLICK_SYNC_EN
    logic [1:0] sync_q;

    // two-stage synchronizer for the asynchronous board button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], btn};
    end

    assign btn_s = sync_q[1];
`else
    assign btn_s = btn;
`endif

    // rising-edge detect, pulse registered so it is glitch-free downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            prev_q    <= btn_s;
            btn_pulse <= btn_s & ~prev_q;
        end
    end

endmodule

// File: rtl/flick_sequencer.sv
// Sequences bound_flasher through a programmed number of flash cycles with
// a programmable gap, and merges the manual button onto the flick line.
// Build option: FLICK_SYNC_EN adds a 2-flop synchronizer on btn.
module flick_sequencer
    import flasher_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned GAP_W = GAP_W_DEF,
    parameter int unsigned TMO   = TMO_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] auto_count,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic [1:0]       flasher_state,
    output logic             flick,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cycles_done,
    output logic [2:0]       seq_state
);

    localparam int unsigned TMO_W = $clog2(TMO + 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             done_pend_q, done_pend_d;
    logic             tmo_err_d;
    logic             flick_d;
    logic             btn_pulse;
    logic             flasher_idle;

    flick_edge_sync u_edge_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .btn_pulse (btn_pulse)
    );

    assign flasher_idle = (flasher_state == FLASHER_IDLE);
    assign cycles_done  = count_q;
    assign seq_state    = state_q;

    // next-state, counters and flick request
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        count_d     = count_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;
        done_pend_d = 1'b0;
        tmo_err_d   = timeout_err;
        flick_d     = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    if (auto_count != '0) begin
                        target_d  = auto_count;
                        count_d   = '0;
                        tmo_err_d = 1'b0;
                        state_d   = SEQ_LAUNCH;
                    end else begin
                        done_pend_d = 1'b1;
                    end
                end
            end
            SEQ_LAUNCH: begin
                flick_d = 1'b1;
                tmo_d   = TMO_W'(TMO);
                state_d = SEQ_WAIT_BUSY;
            end
            SEQ_WAIT_BUSY: begin
                if (!flasher_idle) begin
                    state_d = SEQ_RUN;
                end else if (tmo_q == '0) begin
                    tmo_err_d = 1'b1;
                    state_d   = SEQ_IDLE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            SEQ_RUN: begin
                if (flasher_idle) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_d == target_q) begin
                        done_pend_d = 1'b1;
                        state_d     = SEQ_IDLE;
                    end else begin
                        gap_d   = gap_cycles;
                        state_d = SEQ_GAP;
                    end
                end
            end
            SEQ_GAP: begin
                if (gap_q == '0) state_d = SEQ_LAUNCH;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = SEQ_IDLE;
        endcase

        // manual kick only where it cannot disturb a launch handshake
        if (btn_pulse && (state_q == SEQ_IDLE || state_q == SEQ_RUN)) begin
            flick_d = 1'b1;
        end

        // abort overrides everything and keeps the completed count
        if (abort) begin
            state_d     = SEQ_IDLE;
            target_d    = target_q;
            count_d     = count_q;
            gap_d       = gap_q;
            tmo_d       = tmo_q;
            done_pend_d = 1'b0;
            tmo_err_d   = timeout_err;
            flick_d     = 1'b0;
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEQ_IDLE;
            target_q    <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            tmo_q       <= '0;
            done_pend_q <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            flick       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            done_pend_q <= done_pend_d;
            done        <= done_pend_q;
            timeout_err <= tmo_err_d;
            flick       <= flick_d;
            busy        <= (state_d != SEQ_IDLE);
        end
    end

endmodule

// File: tb/tb_flick_sequencer.sv
// Bench for flick_sequencer: a cycle-level flasher model responds to flick,
// and expected flick/done times come from the sequence timing arithmetic.
module tb_flick_sequencer;

`ifdef FLICK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] auto_count = 4'd0;
    logic [7:0] gap_cycles = 8'd0;
    logic [1:0] flasher_state = 2'b00;
    logic       flick, busy, done, timeout_err;
    logic [3:0] cycles_done;
    logic [2:0] seq_state;

    flick_sequencer #(.CNT_W(4), .GAP_W(8), .TMO(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn           (btn),
        .start         (start),
        .abort         (abort),
        .auto_count    (auto_count),
        .gap_cycles    (gap_cycles),
        .flasher_state (flasher_state),
        .flick         (flick),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err),
        .cycles_done   (cycles_done),
        .seq_state     (seq_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fl_seen[$];
    int done_seen[$];
    int busy_at_done;
    int tmo_first;
    int fl_rem = 0;
    int fl_dur = 4;
    bit fl_dead = 1'b0;
    bit prev_flick = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock: observe outputs after the edge, then advance the flasher model
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (flick === 1'b1) fl_seen.push_back(cyc);
        if (done === 1'b1) begin
            done_seen.push_back(cyc);
            busy_at_done = int'(busy);
        end
        if (timeout_err === 1'b1 && tmo_first == 0) tmo_first = cyc;
        if (prev_flick && flasher_state == 2'b00 && !fl_dead) begin
            flasher_state = 2'b01;
            fl_rem        = fl_dur;
        end else if (flasher_state != 2'b00) begin
            fl_rem--;
            if (fl_rem == 0) flasher_state = 2'b00;
        end
        prev_flick = (flick === 1'b1);
    endtask

    task automatic model_reset();
        flasher_state = 2'b00;
        fl_rem        = 0;
        prev_flick    = 1'b0;
    endtask

    // one auto sequence; abort_k aborts on that completion, never = dead flasher
    task automatic run_seq(input int n, input int g, input int d, input int abort_k,
                           input bit press_run, input bit press_gap, input bit never);
        int s, per, f1, c1, cn, abort_edge, p1, p2, busy_end, fin, e, exp_cd;
        int exp_f[$];
        fl_seen.delete();
        done_seen.delete();
        tmo_first    = 0;
        busy_at_done = -1;
        fl_dur       = d;
        fl_dead      = never;
        auto_count   = 4'(n);
        gap_cycles   = 8'(g);
        s   = cyc + 1;
        per = d + g + 4;
        f1  = s + 1;
        c1  = f1 + d + 2;
        cn  = f1 + (n - 1) * per + d + 2;
        abort_edge = (abort_k > 0) ? f1 + (abort_k - 1) * per + d + 2 : 0;
        p1 = press_run ? f1 + 5 : 0;
        p2 = press_gap ? c1 + 2 : 0;
        if (never) exp_f.push_back(f1);
        else begin
            for (int i = 0; i < n; i++) begin
                if (abort_k == 0 || i < abort_k) exp_f.push_back(f1 + i * per);
                if (i == 0 && press_run) exp_f.push_back(p1 + LAT);
            end
        end
        busy_end = never ? s + 6 : ((abort_k > 0) ? abort_edge : cn);
        fin      = busy_end + 12;
        while (cyc < fin) begin
            e     = cyc + 1;
            start = (e == s) || (e > s && e < busy_end && $urandom_range(0, 3) == 0);
            abort = (abort_edge != 0 && e == abort_edge);
            btn   = (p1 != 0 && e >= p1 && e < p1 + 3) || (p2 != 0 && e >= p2 && e < p2 + 3);
            step();
            if (cyc == s) auto_count = 4'($urandom);
            if (cyc == c1 && !never) check("cnt_after_first", cycles_done, (abort_k == 1) ? 0 : 1);
            if (abort_edge != 0 && cyc == abort_edge) begin
                check("abort_flick", flick, 0);
                check("abort_busy", busy, 0);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        btn   = 1'b0;
        check("flick_count", fl_seen.size(), exp_f.size());
        for (int i = 0; i < exp_f.size() && i < fl_seen.size(); i++)
            check($sformatf("flick_at[%0d]", i), fl_seen[i], exp_f[i]);
        if (abort_k == 0 && !never) begin
            check("done_count", done_seen.size(), 1);
            if (done_seen.size() > 0) check("done_at", done_seen[0], cn + 1);
            check("busy_at_done", busy_at_done, 0);
        end else begin
            check("no_done", done_seen.size(), 0);
        end
        exp_cd = never ? 0 : ((abort_k > 0) ? abort_k - 1 : n);
        check("cycles_done", cycles_done, exp_cd);
        check("end_state", seq_state, 0);
        check("end_busy", busy, 0);
        if (never) begin
            check("tmo_at", tmo_first, f1 + 5);
            check("tmo_sticky", timeout_err, 1);
        end else begin
            check("tmo_clear", timeout_err, 0);
        end
    endtask

    initial begin
        int s;
        #1;
        check("rst_outs", {flick, busy, done, timeout_err, cycles_done, seq_state}, 0);
        #23;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_outs", {flick, busy, done, timeout_err, cycles_done, seq_state}, 0);
        end

        run_seq(3, 5, 40, 0, 1'b0, 1'b0, 1'b0);
        run_seq(2, 3, 5, 0, 1'b0, 1'b0, 1'b1);
        run_seq(3, 2, 6, 2, 1'b0, 1'b0, 1'b0);
        run_seq(2, 10, 20, 0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++)
            run_seq(int'($urandom_range(1, 4)), int'($urandom_range(0, 6)),
                    int'($urandom_range(3, 12)), 0, 1'b0, 1'b0, 1'b0);

        // reset while in LAUNCH
        auto_count = 4'd2;
        gap_cycles = 8'd1;
        fl_dead    = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("launch_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_launch_busy", busy, 0);
        check("rst_launch_flick", flick, 0);
        check("rst_launch_state", seq_state, 0);
        #2 rst_n = 1'b1;
        model_reset();

        // reset while flick is high
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("flick_before_rst", flick, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_flick", flick, 0);
        check("rst_busy", busy, 0);
        #2 rst_n = 1'b1;
        model_reset();
        step();
        step();

        // zero count start: done only, no launch
        fl_seen.delete();
        done_seen.delete();
        auto_count = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        s = cyc;
        for (int i = 0; i < 6; i++) step();
        check("zero_done_count", done_seen.size(), 1);
        if (done_seen.size() > 0) check("zero_done_at", done_seen[0], s + 1);
        check("zero_no_flick", fl_seen.size(), 0);
        check("zero_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flick_sequencer.md
# flick_sequencer

Controller that sequences the `bound_flasher` datapath through a programmed number of complete flash cycles. It launches each cycle with a one-cycle `flick` pulse, monitors the flasher's state to detect cycle completion, and inserts a programmable gap between cycles. It also arbitrates a synchronized manual push-button onto the same `flick` line. It sits between the board-level button/config registers and the `bound_flasher` `flick` input.

## Interface
- `CNT_W`, 4, width of cycle-count target and completed-cycle counter
- `GAP_W`, 8, width of inter-cycle gap counter
- `TMO`, 4, cycles allowed for the flasher to leave idle after a launch flick
- `clk`  input  1  system clock, rising-edge
- `rst_n`  input  1  asynchronous active-low reset
- `btn`  input  1  raw manual flick button, active-high
- `start`  input  1  begin an auto sequence (sampled level, acts on first cycle high in IDLE)
- `abort`  input  1  terminate the sequence immediately
- `auto_count`  input  CNT_W  number of flasher cycles to run
- `gap_cycles`  input  GAP_W  idle clocks between cycles
- `flasher_state`  input  2  `state` output of `bound_flasher`
- `flick`  output  1  to `bound_flasher.flick`, registered
- `busy`  output  1  high in any state other than IDLE
- `done`  output  1  one-cycle pulse when the programmed count completes
- `timeout_err`  output  1  sticky; the flasher failed to start within TMO cycles
- `cycles_done`  output  CNT_W  completed cycles in the current or last sequence
- `seq_state`  output  3  current FSM state, for debug

## Operation
- FSM states: IDLE, LAUNCH, WAIT_BUSY, RUN, GAP.
- IDLE:
  - `start` with `auto_count`≠0: latch `auto_count`, clear `cycles_done` and `timeout_err`, go to LAUNCH.
  - `start` with `auto_count`=0: pulse `done` next cycle, stay in IDLE, no flick.
- LAUNCH: `flick`=1 for exactly one cycle, then go to WAIT_BUSY and load the timeout counter with TMO.
- WAIT_BUSY:
  - `flasher_state`≠FLASHER_IDLE: go to RUN.
  - Timeout counter reaches 0: set `timeout_err` and go to IDLE.
- RUN: on `flasher_state`==FLASHER_IDLE, increment `cycles_done`.
  - New count equals the target: pulse `done` and go to IDLE.
  - Otherwise: load `gap_cycles` and go to GAP.
- GAP: count down to 0, then go to LAUNCH. `gap_cycles`=0 means LAUNCH on the next cycle.
- Manual button: synchronized rising edge → `btn_pulse`.
  - Forwarded as a one-cycle `flick` in IDLE and RUN; in RUN it is a mid-cycle kick to the flasher.
  - Dropped in LAUNCH, WAIT_BUSY and GAP.
  - It never changes FSM state. In IDLE, a manual flick does not count toward `cycles_done`.
- `flick` is the registered OR of the LAUNCH pulse and the accepted `btn_pulse`. It never stays high for more than one cycle per event.
- `cycles_done` saturates at the target and holds its value after `done`, `abort` or timeout until the next accepted `start`.

## Timing
- Reset (async, immediate): state IDLE; `flick`, `busy`, `done`, `timeout_err`=0; `cycles_done`=0; `seq_state`=IDLE.
- `start` sampled at edge k in IDLE → LAUNCH after edge k → `flick` high after edge k+1 for one cycle.
- Completion detected at edge k in RUN → `done` high after edge k+1 for one cycle, with `busy` low in that same cycle.
- Gap: the `flick` rise of the next cycle follows the completion edge by `gap_cycles`+2 clocks.
- Simultaneous events:
  - `abort` beats every other event: IDLE next cycle, `flick` forced 0, no `done`, `cycles_done` retained.
  - Completion and `abort` in the same cycle: no increment.
  - `start` outside IDLE is ignored.
- Reset mid-sequence: `flick` drops asynchronously and the sequence is lost.

## Configuration
- `FLICK_SYNC_EN` defined:
  - `btn` passes a 2-flop synchronizer before edge detection.
  - `btn` high first sampled at edge k → `flick` high after edge k+3.
- `FLICK_SYNC_EN` undefined:
  - `btn` is treated as synchronous; edge detection only.
  - `btn` high first sampled at edge k → `flick` high after edge k+1.

## Structure
- Shared package `flasher_pkg`:
  - FSM state enum (3-bit).
  - `FLASHER_IDLE` = 2'b00, the `bound_flasher` idle state encoding.
  - Default `TMO`.
- Sub-module `flick_edge_sync`:
  - Optional synchronizer plus rising-edge detector.
  - Output is a one-cycle `btn_pulse`.
- Top level holds the FSM, the gap, timeout and cycle counters, and the `flick` output register.

## Test plan
- Reset release, no stimulus → all outputs 0 and `seq_state`=IDLE for 20 cycles.
- `auto_count`=3, `gap_cycles`=5, flasher model busy for 40 cycles per flick:
  - exactly 3 one-cycle flicks, each 7 clocks after the previous completion;
  - `done` once; `cycles_done`=3.
- Flasher model never leaves idle, `TMO`=4 → `timeout_err`=1 five cycles after the flick, IDLE, no `done`.
- `abort` asserted in RUN on the same cycle the flasher returns idle → IDLE, `flick`=0, no `done`, `cycles_done` unchanged.
- `btn` pressed in RUN and again in GAP:
  - the RUN press yields one flick with latency 3 (macro on) or 1 (macro off);
  - the GAP press yields no flick.
- Assert `rst_n`=0 during LAUNCH → `flick` and `busy` drop without waiting for a clock edge; `start` with `auto_count`=0 → `done` pulse, no flick.
